// File: rtl/alu.sv
// Registered N-bit ALU: one-cycle latency, result and overflow/negative/zero flags.
// sync_reset clears only the result so a following branch still sees the last flags.
module alu #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync_reset,
    input  logic [2:0]   opcode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic [2:0]   onz
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_INC = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [N-1:0] ONE     = N'(1);
    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};

    logic [N-1:0] r_result;
    logic [2:0]   r_onz;

    logic [N-1:0] w_res;
    logic         w_ovf;
    logic         w_op_ok;

    always_comb begin
        w_res   = '0;
        w_ovf   = 1'b0;
        w_op_ok = 1'b1;
        case (opcode)
            OP_ADD: begin
                w_res = a + b;
                w_ovf = (a[N-1] == b[N-1]) && (w_res[N-1] != a[N-1]);
            end
            OP_SUB: begin
                w_res = a - b;
                w_ovf = (a[N-1] != b[N-1]) && (w_res[N-1] != a[N-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_INC: begin
                w_res = a + ONE;
                w_ovf = (a == MAX_POS);
            end
            OP_MOV: w_res = b;
            OP_NOP: w_res = a;
            // Only reachable with an unknown opcode: leave state untouched.
            default: w_op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_onz    <= 3'b000;
        end else if (sync_reset) begin
            r_result <= '0;
        end else if (en && w_op_ok) begin
            r_result <= w_res;
            r_onz    <= {w_ovf, w_res[N-1], (w_res == '0)};
        end
    end

    assign result = r_result;
    assign onz    = r_onz;

    a_known_opcode: assert property (@(posedge clk) disable iff (!rst_n)
        (en && !sync_reset) |-> !$isunknown(opcode))
        else $error("alu: unknown opcode with en=1");

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu (N=8): driver pushes expected {onz,result}
// per cycle, a monitor pops and compares one time unit after each rising edge.
module tb_alu;

    localparam int N = 8;
    localparam int W = N + 3;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] INC = 3'b101;
    localparam logic [2:0] MOV = 3'b110;
    localparam logic [2:0] NOP = 3'b111;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         sync_reset;
    logic [2:0]   opcode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] result;
    logic [2:0]   onz;

    logic [W-1:0] exp_q[$];
    int           id_q[$];
    int           total;
    int           bad;
    int           vec_id;

    alu #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sync_reset (sync_reset),
        .opcode     (opcode),
        .a          (a),
        .b          (b),
        .result     (result),
        .onz        (onz)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // direct check used where no clock edge is involved (async reset)
    task automatic check_now(input string name, input logic [W-1:0] exp);
        total++;
        if ({onz, result} !== exp) begin
            bad++;
            $display("FAIL %s: got onz=%b result=%h, expected onz=%b result=%h",
                     name, onz, result, exp[W-1:N], exp[N-1:0]);
        end
    endtask

    // driver: apply one cycle of inputs at the falling edge, queue the expected outputs
    task automatic step(input logic e, input logic sr, input logic [2:0] op,
                        input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [2:0] exp_onz, input logic [N-1:0] exp_res);
        @(negedge clk);
        en         = e;
        sync_reset = sr;
        opcode     = op;
        a          = va;
        b          = vb;
        vec_id++;
        exp_q.push_back({exp_onz, exp_res});
        id_q.push_back(vec_id);
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        int           id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                total++;
                if ({onz, result} !== e) begin
                    bad++;
                    $display("FAIL vec%0d: got onz=%b result=%h, expected onz=%b result=%h",
                             id, onz, result, e[W-1:N], e[N-1:0]);
                end
            end
        end
    end

    initial begin
        total = 0; bad = 0; vec_id = 0;
        rst_n = 1'b0; en = 1'b0; sync_reset = 1'b0; opcode = ADD; a = '0; b = '0;
        #2;
        check_now("reset_async", {3'b000, 8'h00});
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_held", {3'b000, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;

        // ADD overflow then hold for three idle cycles
        step(1, 0, ADD, 8'h7F, 8'h01, 3'b110, 8'h80);
        step(0, 0, SUB, 8'h12, 8'h34, 3'b110, 8'h80);
        step(0, 0, XOR, 8'hAA, 8'h55, 3'b110, 8'h80);
        step(0, 0, INC, 8'h00, 8'h00, 3'b110, 8'h80);
        // logic ops and flag clearing
        step(1, 0, XOR, 8'hF0, 8'h3C, 3'b010, 8'hCC);
        step(1, 0, AND, 8'hF0, 8'h3C, 3'b000, 8'h30);
        step(1, 0, MOV, 8'hF0, 8'h3C, 3'b000, 8'h3C);
        step(1, 0, NOP, 8'hF0, 8'h3C, 3'b010, 8'hF0);
        step(1, 0, OR,  8'hF0, 8'h3C, 3'b010, 8'hFC);
        // zero results, carry discarded
        step(1, 0, SUB, 8'h05, 8'h05, 3'b001, 8'h00);
        step(1, 0, ADD, 8'hFF, 8'h01, 3'b001, 8'h00);
        // further overflow cases
        step(1, 0, SUB, 8'h80, 8'h01, 3'b100, 8'h7F);
        step(1, 0, ADD, 8'h80, 8'h80, 3'b101, 8'h00);
        step(1, 0, SUB, 8'h7F, 8'hFF, 3'b110, 8'h80);
        // INC boundaries
        step(1, 0, INC, 8'h7F, 8'h00, 3'b110, 8'h80);
        step(1, 0, INC, 8'hFF, 8'h00, 3'b001, 8'h00);
        // sync_reset keeps flags, wins over en
        step(1, 0, SUB, 8'h01, 8'h02, 3'b010, 8'hFF);
        step(1, 1, ADD, 8'h10, 8'h10, 3'b010, 8'h00);
        step(0, 0, ADD, 8'h10, 8'h10, 3'b010, 8'h00);
        step(1, 0, ADD, 8'h10, 8'h10, 3'b000, 8'h20);
        step(0, 1, ADD, 8'h10, 8'h10, 3'b000, 8'h00);
        // async reset during a stream of ADDs
        step(1, 0, ADD, 8'h01, 8'h02, 3'b000, 8'h03);
        step(1, 0, ADD, 8'h40, 8'h41, 3'b110, 8'h81);
        @(negedge clk);
        a = 8'h11; b = 8'h22; opcode = ADD; en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_drop", {3'b000, 8'h00});
        repeat (2) @(posedge clk);
        #1;
        check_now("async_hold", {3'b000, 8'h00});
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b1;
        step(0, 0, ADD, 8'h11, 8'h22, 3'b000, 8'h00);
        step(0, 0, ADD, 8'h11, 8'h22, 3'b000, 8'h00);
        step(1, 0, ADD, 8'h11, 8'h22, 3'b000, 8'h33);

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter N, default 8, data word width in bits (SHALL be >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  operation enable; result/flags update only when high.
REQ-005 sync_reset  input  1  synchronous clear of result register.
REQ-006 opcode  input  3  operation select, encoding per REQ-012.
REQ-007 a  input  N  operand A (register file port A).
REQ-008 b  input  N  operand B (register file port B).
REQ-009 result  output  N  registered operation result, two's complement.
REQ-010 onz  output  3  registered flags: [2] overflow, [1] negative, [0] zero.

Function
REQ-011 result and onz SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-012 Opcode encoding SHALL be:
- 000 ADD: a+b
- 001 SUB: a-b
- 010 AND: a&b
- 011 OR: a|b
- 100 XOR: a^b
- 101 INC: a+1
- 110 MOV: b
- 111 NOP: a
REQ-013 Latency SHALL be one cycle: operands and opcode sampled at edge k with en=1 appear on result/onz after edge k.
REQ-014 With en=0 and sync_reset=0, result and onz SHALL hold their values.
REQ-015 Arithmetic SHALL be modulo 2^N; any carry out of bit N-1 SHALL be discarded and SHALL NOT be reported.
REQ-016 onz[2] SHALL be set on signed overflow:
- ADD: a and b have the same sign and the result sign differs.
- SUB: a and b have different signs and the result sign differs from a.
- INC: a = 2^(N-1)-1.
REQ-017 onz[2] SHALL be 0 after AND, OR, XOR, MOV and NOP.
REQ-018 onz[1] SHALL equal bit N-1 of the new result; onz[0] SHALL be 1 iff the new result is all-zero; both SHALL be updated for every opcode, including NOP.
REQ-019 sync_reset=1 SHALL clear result to 0 on the next edge and SHALL leave onz unchanged, so that a following conditional branch still sees the flags of the last operation.
REQ-020 sync_reset SHALL take priority over en when both are high: result cleared, onz held, operands ignored.
REQ-021 An unknown/X opcode with en=1 is illegal; the implementation SHALL flag it with a simulation assertion and SHALL NOT update state.
REQ-022 Back-to-back enabled operations SHALL be supported every cycle, each result depending only on that cycle's inputs.

Reset
REQ-023 rst_n low SHALL asynchronously force result=0 and onz=3'b000, independent of clk.
REQ-024 rst_n low SHALL override en and sync_reset; the first update after release occurs on the first rising edge with rst_n high and en or sync_reset high.
REQ-025 Assertion of rst_n mid-sequence SHALL discard any in-flight operation; no output SHALL reflect pre-reset inputs after release.

Verification (N=8)
REQ-026 ADD overflow: a=0x7F, b=0x01, en=1 -> next cycle result=0x80, onz=3'b110; then en=0 for 3 cycles -> outputs unchanged.
REQ-027 SUB to zero and carry discard:
- a=0x05, b=0x05, SUB -> result=0x00, onz=3'b001.
- a=0xFF, b=0x01, ADD -> result=0x00, onz=3'b001 (no overflow).
REQ-028 Logic ops and flag clearing: after the REQ-026 step, a=0xF0, b=0x3C:
- XOR -> result=0xCC, onz=3'b010.
- AND -> 0x30, onz=3'b000.
- MOV -> 0x3C, onz=3'b000.
- NOP -> 0xF0, onz=3'b010.
REQ-029 INC boundary: a=0x7F, INC -> 0x80, onz=3'b110; a=0xFF, INC -> 0x00, onz=3'b001.
REQ-030 sync_reset flag retention: SUB a=0x01, b=0x02 -> result=0xFF, onz=3'b010; next cycle sync_reset=1, en=1, ADD a=0x10, b=0x10 -> result=0x00, onz=3'b010.
REQ-031 Async reset: during a stream of enabled ADDs, drop rst_n between edges -> result=0, onz=0 immediately; hold 2 cycles, release with en=0 -> outputs stay 0 until the next enabled edge.
